fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter FW_WIDTH, default 41, width of fetch word passed to decode.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset (rst=0 resets).
REQ-005 should_stall  input  1  decode stalled; fetch SHALL hold its output.
REQ-006 redirect_valid  input  1  branch/jump resolved taken this cycle.
REQ-007 redirect_pc  input  16  target PC for redirect.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  16  word address of request (current PC).
REQ-010 imem_ack  input  1  imem_rdata valid for the outstanding request.
REQ-011 imem_rdata  input  16  fetched instruction.
REQ-012 instr_out  output  41  fetch word: [40:25] instruction ([40:37] opcode, [36:34] ra, [33:31] rb, [30:28] rc), [24:9] PC of instruction, [8] valid, [7:0] zero.

Function
REQ-013 States SHALL be START, REQ, HOLD; START lasts exactly one cycle after rst deassert, then REQ.
REQ-014 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; in START and HOLD, imem_req SHALL be 0.
REQ-015 REQ, imem_ack=1, should_stall=0: instr_out <= {imem_rdata, pc, 1'b1, 8'd0}; pc <= pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000); stay REQ.
REQ-016 REQ, imem_ack=1, should_stall=1: capture word in hold register; instr_out unchanged; pc unchanged; go HOLD.
REQ-017 REQ, imem_ack=0: instr_out <= 41'd0 (bubble) if should_stall=0, else unchanged.
REQ-018 HOLD, should_stall=0: instr_out <= hold register; pc <= pc+1; go REQ; should_stall=1: remain HOLD, all outputs unchanged.
REQ-019 redirect_valid=1 SHALL take priority in any state: pc <= redirect_pc, instr_out <= 41'd0, hold register discarded, any same-cycle imem_ack discarded, next state REQ.
REQ-020 Output latency SHALL be one cycle from imem_ack to instr_out when not stalled; sustained throughput one instruction per cycle.
REQ-021 instr_out[7:0] SHALL always be zero; instr_out SHALL be registered (no combinational path from inputs).

Reset
REQ-022 rst=0 SHALL asynchronously force pc=RESET_PC, state=START, instr_out=41'd0, hold register=0, imem_req=0, imem_addr=RESET_PC.
REQ-023 Reset asserted mid-REQ or mid-HOLD SHALL abandon the outstanding request; an imem_ack arriving during reset SHALL be ignored.

Configuration
REQ-024 Macro FETCH_PERF_EN defined: output bubble_cnt (32 bits) SHALL increment (wrapping) each cycle a bubble (valid=0) is written to instr_out by REQ-017 or REQ-019, reset to 0 by rst.
REQ-025 FETCH_PERF_EN undefined: port bubble_cnt and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-026 Shared package iitb_risc_pkg SHALL hold FW_WIDTH, fetch-word field bit positions, 4-bit opcode constants, and the fetch state enum.
REQ-027 Sub-module pc_gen SHALL own the PC register, increment and redirect mux; fetch owns FSM, hold register and output register.

Verification
REQ-028 Reset release, imem_ack held 1, imem_rdata=16'h2A55, should_stall=0 -> imem_addr 0,1,2...; instr_out = {16'h2A55,16'h0000,1,8'h00} one cycle after first ack.
REQ-029 Ack at pc=16'h0005 with should_stall=1 for 3 cycles -> imem_req=0 for 3 cycles, instr_out unchanged; after release instr_out carries PC 16'h0005, next imem_addr=16'h0006.
REQ-030 redirect_valid=1, redirect_pc=16'h0100 in same cycle as imem_ack -> instr_out=41'd0 next cycle, next imem_addr=16'h0100, acked data never appears.
REQ-031 pc=16'hFFFF acked, not stalled -> instr_out PC field 16'hFFFF, next imem_addr=16'h0000.
REQ-032 rst pulsed low while in HOLD -> instr_out=0, imem_addr=RESET_PC immediately; one START cycle with imem_req=0, then REQ.
REQ-033 FETCH_PERF_EN defined, imem_ack=0 for 4 unstalled cycles -> bubble_cnt increases by 4; with should_stall=1 in those cycles -> unchanged.

Source files
------------

// File: rtl/iitb_risc_pkg.sv
// Shared definitions for the IITB-RISC front end: fetch-word layout, opcodes,
// fetch FSM encoding and a fetch-word packing helper.
package iitb_risc_pkg;

  localparam int FW_WIDTH    = 41;
  localparam int FW_INSTR_HI = 40;
  localparam int FW_INSTR_LO = 25;
  localparam int FW_OP_HI    = 40;
  localparam int FW_OP_LO    = 37;
  localparam int FW_RA_HI    = 36;
  localparam int FW_RA_LO    = 34;
  localparam int FW_RB_HI    = 33;
  localparam int FW_RB_LO    = 31;
  localparam int FW_RC_HI    = 30;
  localparam int FW_RC_LO    = 28;
  localparam int FW_PC_HI    = 24;
  localparam int FW_PC_LO    = 9;
  localparam int FW_VALID    = 8;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_ADI = 4'b0000;
  localparam logic [3:0] OP_NAN = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Valid fetch word; bits [7:0] stay zero.
  function automatic logic [FW_WIDTH-1:0] make_fw(input logic [15:0] instr,
                                                  input logic [15:0] pc);
    make_fw = '0;
    make_fw[FW_INSTR_HI:FW_INSTR_LO] = instr;
    make_fw[FW_PC_HI:FW_PC_LO]       = pc;
    make_fw[FW_VALID]                = 1'b1;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter: holds the fetch PC, increments on advance, and takes the
// redirect target with priority.
module pc_gen #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        advance,
  output logic [15:0] pc
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: START/REQ/HOLD FSM, stall hold register and the
// registered fetch word to decode. Optional FETCH_PERF_EN adds bubble_cnt.
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          FW_WIDTH = iitb_risc_pkg::FW_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                should_stall,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  output logic                imem_req,
  output logic [15:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [FW_WIDTH-1:0] instr_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         bubble_cnt
`endif
);

  import iitb_risc_pkg::*;

  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_REQ   = ST_REQ;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]          state, state_d;
  logic [15:0]         pc;
  logic                advance;
  logic [FW_WIDTH-1:0] fetched, hold_q, hold_d, out_d;

  pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc             (pc)
  );

  assign fetched   = FW_WIDTH'(make_fw(imem_rdata, pc));
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    out_d   = instr_out;
    hold_d  = hold_q;
    advance = 1'b0;
    if (redirect_valid) begin
      state_d = S_REQ;
      out_d   = '0;
      hold_d  = '0;
    end else begin
      case (state)
        S_START: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack && should_stall) begin
            hold_d  = fetched;
            state_d = S_HOLD;
          end else if (imem_ack) begin
            out_d   = fetched;
            advance = 1'b1;
          end else if (!should_stall) begin
            out_d = '0;
          end
        end
        S_HOLD: begin
          if (!should_stall) begin
            out_d   = hold_q;
            advance = 1'b1;
            state_d = S_REQ;
          end
        end
        default: state_d = S_START;
      endcase
    end
  end

  // NOTE: the hold word is reset with the rest of the state so a stall after reset can never replay stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_START;
      instr_out <= '0;
      hold_q    <= '0;
    end else begin
      state     <= state_d;
      instr_out <= out_d;
      hold_q    <= hold_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble;

  // Bubbles: redirect flush in any state, or an unstalled REQ cycle with no ack.
  assign bubble = redirect_valid ||
                  ((state == S_REQ) && !imem_ack && !should_stall);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= 32'd0;
    end else if (bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch; build with FETCH_PERF_EN defined to
// also exercise bubble_cnt.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        should_stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [40:0] instr_out;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fetch #(.RESET_PC(16'h0000), .FW_WIDTH(41)) dut (
    .clk            (clk),
    .rst            (rst),
    .should_stall   (should_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] word(input logic [15:0] instr, input logic [15:0] pc);
    return {instr, pc, 1'b1, 8'h00};
  endfunction

  // Advance one rising edge; outputs are then sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; should_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    repeat (3) step();
    tests_run++;
    if (instr_out !== 41'd0) begin
      tests_failed++; $display("FAIL reset_instr_out got=%h want=%h", instr_out, 41'd0);
    end
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_imem got req=%b addr=%h want req=0 addr=0000", imem_req, imem_addr);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL start_no_req got=%b want=0", imem_req);
    end
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    imem_ack = 1'b1; imem_rdata = 16'h2A55;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (instr_out !== word(16'h2A55, 16'(i)) || imem_addr !== 16'(i + 1)) begin
        tests_failed++;
        $display("FAIL stream_%0d got out=%h addr=%h want out=%h addr=%h",
                 i, instr_out, imem_addr, word(16'h2A55, 16'(i)), 16'(i + 1));
      end
    end
    imem_ack = 1'b0;
    step();
    tests_run++;
    if (instr_out !== 41'd0 || imem_addr !== 16'h0003) begin
      tests_failed++; $display("FAIL no_ack_bubble got out=%h addr=%h want out=0 addr=0003", instr_out, imem_addr);
    end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    step();
    step();
    tests_run++;
    if (instr_out !== word(16'h1234, 16'h0004) || imem_addr !== 16'h0005) begin
      tests_failed++; $display("FAIL pre_stall got out=%h addr=%h want out=%h addr=0005",
                               instr_out, imem_addr, word(16'h1234, 16'h0004));
    end
    imem_rdata = 16'hBEEF; should_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ack = 1'b0;
      tests_run++;
      if (imem_req !== 1'b0 || instr_out !== word(16'h1234, 16'h0004) || imem_addr !== 16'h0005) begin
        tests_failed++; $display("FAIL stall_hold_%0d got req=%b out=%h addr=%h want req=0 out=%h addr=0005",
                                 i, imem_req, instr_out, imem_addr, word(16'h1234, 16'h0004));
      end
    end
    should_stall = 1'b0;
    step();
    tests_run++;
    if (instr_out !== word(16'hBEEF, 16'h0005) || imem_addr !== 16'h0006 || imem_req !== 1'b1) begin
      tests_failed++; $display("FAIL stall_release got out=%h addr=%h req=%b want out=%h addr=0006 req=1",
                               instr_out, imem_addr, imem_req, word(16'hBEEF, 16'h0005));
    end
  endtask

  task automatic test_redirect();
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    tests_run++;
    if (instr_out !== 41'd0 || imem_addr !== 16'h0100 || imem_req !== 1'b1) begin
      tests_failed++; $display("FAIL redirect got out=%h addr=%h req=%b want out=0 addr=0100 req=1",
                               instr_out, imem_addr, imem_req);
    end
    step();
    tests_run++;
    if (instr_out !== 41'd0 || imem_addr !== 16'h0100) begin
      tests_failed++; $display("FAIL redirect_drop got out=%h addr=%h want out=0 addr=0100", instr_out, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h4321;
    step();
    imem_ack = 1'b0;
    tests_run++;
    if (instr_out !== word(16'h4321, 16'hFFFF) || imem_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL pc_wrap got out=%h addr=%h want out=%h addr=0000",
                               instr_out, imem_addr, word(16'h4321, 16'hFFFF));
    end
    should_stall = 1'b1;
    step();
    tests_run++;
    if (instr_out !== word(16'h4321, 16'hFFFF) || imem_req !== 1'b1) begin
      tests_failed++; $display("FAIL stalled_no_ack got out=%h req=%b want out=%h req=1",
                               instr_out, imem_req, word(16'h4321, 16'hFFFF));
    end
  endtask

  task automatic test_reset_in_hold();
    imem_ack = 1'b1; imem_rdata = 16'h7777; should_stall = 1'b1;
    step();
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL enter_hold got req=%b want=0", imem_req);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (instr_out !== 41'd0 || imem_addr !== 16'h0000 || imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset got out=%h addr=%h req=%b want out=0 addr=0000 req=0",
                               instr_out, imem_addr, imem_req);
    end
    step();
    rst = 1'b1; imem_ack = 1'b0; should_stall = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || instr_out !== 41'd0) begin
      tests_failed++; $display("FAIL reset_start got req=%b out=%h want req=0 out=0", imem_req, instr_out);
    end
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_out !== 41'd0) begin
      tests_failed++; $display("FAIL reset_to_req got req=%b addr=%h out=%h want req=1 addr=0000 out=0",
                               imem_req, imem_addr, instr_out);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst = 1'b0; imem_ack = 1'b0; should_stall = 1'b0; redirect_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bubble_cnt !== 32'd0) begin
      tests_failed++; $display("FAIL perf_reset got=%0d want=0", bubble_cnt);
    end
    step();
    repeat (4) step();
    tests_run++;
    if (bubble_cnt !== 32'd4) begin
      tests_failed++; $display("FAIL perf_bubbles got=%0d want=4", bubble_cnt);
    end
    should_stall = 1'b1;
    repeat (4) step();
    tests_run++;
    if (bubble_cnt !== 32'd4) begin
      tests_failed++; $display("FAIL perf_stalled got=%0d want=4", bubble_cnt);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0; should_stall = 1'b0;
    tests_run++;
    if (bubble_cnt !== 32'd5) begin
      tests_failed++; $display("FAIL perf_redirect got=%0d want=5", bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_in_hold();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
